id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/immediate width.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports id_valid_i, id_RegDst_i, id_ALUSrc_i, id_MemRead_i, id_MemWrite_i, id_MemtoReg_i, id_RegWrite_i  input  1 each  ID-stage valid and control bits.
REQ-007 SHALL have port id_ALUOp_i  input  2  ALU operation class.
REQ-008 SHALL have ports id_RsAddr_i, id_RtAddr_i, id_RdAddr_i  input  REG_AW each  ID register addresses.
REQ-009 SHALL have ports id_RsData_i, id_RtData_i, id_Imm_i  input  DATA_W each  register-file data and sign-extended immediate.
REQ-010 SHALL have port flush_i  input  1  kill the instruction in ID (taken branch/jump).
REQ-011 SHALL have port hold_i  input  1  downstream freeze (memory wait).
REQ-012 SHALL have port stall_o  output  1  hold PC and IF/ID this cycle.
REQ-013 SHALL have ports ex_valid_o, ex_ALUSrc_o, ex_MemRead_o, ex_MemWrite_o, ex_MemtoReg_o, ex_RegWrite_o  output  1 each; ex_ALUOp_o  output  2; ex_RsAddr_o, ex_RtAddr_o, ex_WriteAddr_o  output  REG_AW; ex_RsData_o, ex_RtData_o, ex_Imm_o  output  DATA_W -- registered EX-stage state, feeds forwarding unit and ALU.
REQ-014 SHALL have port bubble_cnt_o  output  CNT_W  count of load-use bubbles inserted.

Function
REQ-015 Load-use hazard SHALL be: ex_valid_o & ex_MemRead_o & ex_WriteAddr_o!=0 & id_valid_i & (ex_WriteAddr_o==id_RsAddr_i | ex_WriteAddr_o==id_RtAddr_i).
REQ-016 stall_o SHALL be combinational: hold_i | (hazard & ~flush_i).
REQ-017 Update priority per edge SHALL be: rst_i > hold_i > flush_i > hazard > normal load.
REQ-018 hold_i=1: every ex_* register and bubble_cnt_o SHALL keep its value; flush_i and hazard ignored that cycle.
REQ-019 flush_i=1 or hazard=1 (hold_i=0): SHALL load a bubble -- ex_valid_o and all ex_* control bits 0, ex_*Addr_o 0, data fields 0.
REQ-020 Normal load: ex_* SHALL capture id_* one cycle later (latency 1); ex_valid_o=id_valid_i.
REQ-021 ex_WriteAddr_o SHALL capture id_RdAddr_i when id_RegDst_i=1, else id_RtAddr_i.
REQ-022 With id_valid_i=0 on normal load, all captured control bits SHALL be forced 0.
REQ-023 A load-use hazard SHALL produce exactly one bubble; ID instruction enters EX on the following non-hold edge.
REQ-024 bubble_cnt_o SHALL increment by 1 per bubble inserted due to hazard (not flush), saturating at all-ones.
REQ-025 hazard and flush_i in same cycle: bubble loaded, stall_o=0, counter unchanged.

Reset
REQ-026 rst_i=1 at an edge SHALL zero every ex_* output and bubble_cnt_o, overriding hold_i, including mid-stall.
REQ-027 stall_o SHALL be 0 during and after reset until a hazard or hold_i occurs.

Structure
REQ-028 Package cpu_pkg SHALL hold DATA_W/REG_AW defaults, ALUOp encodings and the ID/EX control-bundle typedef.
REQ-029 Hazard comparison SHALL be a combinational sub-module hazard_detection_unit; register and counter stay in id_ex_stage.

Verification
REQ-030 lw $2 in EX (WriteAddr=2), ID Rs=2 -> stall_o=1 one cycle, next ex_valid_o=0, bubble_cnt_o 0->1, then ID instr enters EX.
REQ-031 lw with WriteAddr=0, ID Rs=0 -> stall_o=0, no bubble, counter unchanged.
REQ-032 hazard + flush_i same cycle -> stall_o=0, bubble loaded, bubble_cnt_o unchanged.
REQ-033 hold_i=1 for 3 cycles with id_* changing -> ex_* and counter constant, stall_o=1 throughout.
REQ-034 RegDst=1 Rd=7 Rt=3 -> ex_WriteAddr_o=7; RegDst=0 -> 3.
REQ-035 counter preset to 0xFFFF via hazards, one more hazard -> stays 0xFFFF; rst_i during stall -> all outputs 0 next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: default widths, ALU operation classes and
// the control bundle carried from ID into EX.
package cpu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 5;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SUB   = 2'b01,
      ALU_OP_FUNCT = 2'b10,
      ALU_OP_IMM   = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic    valid;
      logic    alu_src;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    reg_write;
      alu_op_e alu_op;
   } id_ex_ctrl_t;

   localparam id_ex_ctrl_t CTRL_BUBBLE = '{
      valid:      1'b0,
      alu_src:    1'b0,
      mem_read:   1'b0,
      mem_write:  1'b0,
      mem_to_reg: 1'b0,
      reg_write:  1'b0,
      alu_op:     ALU_OP_ADD
   };

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX pipeline bus: decoded instruction, pipeline control in, registered
// EX state and stall/bubble status out.
interface id_ex_stage_if
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = CNT_W_DEF
);
   logic              id_valid;
   logic              id_reg_dst;
   logic              id_alu_src;
   logic              id_mem_read;
   logic              id_mem_write;
   logic              id_mem_to_reg;
   logic              id_reg_write;
   logic [1:0]        id_alu_op;
   logic [REG_AW-1:0] id_rs_addr;
   logic [REG_AW-1:0] id_rt_addr;
   logic [REG_AW-1:0] id_rd_addr;
   logic [DATA_W-1:0] id_rs_data;
   logic [DATA_W-1:0] id_rt_data;
   logic [DATA_W-1:0] id_imm;
   logic              flush;
   logic              hold;

   logic              stall;
   logic              ex_valid;
   logic              ex_alu_src;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              ex_mem_to_reg;
   logic              ex_reg_write;
   logic [1:0]        ex_alu_op;
   logic [REG_AW-1:0] ex_rs_addr;
   logic [REG_AW-1:0] ex_rt_addr;
   logic [REG_AW-1:0] ex_write_addr;
   logic [DATA_W-1:0] ex_rs_data;
   logic [DATA_W-1:0] ex_rt_data;
   logic [DATA_W-1:0] ex_imm;
   logic [CNT_W-1:0]  bubble_cnt;

   // Decode/control side: supplies the ID instruction, observes EX state.
   modport master (
      output id_valid, id_reg_dst, id_alu_src, id_mem_read, id_mem_write,
             id_mem_to_reg, id_reg_write, id_alu_op, id_rs_addr, id_rt_addr,
             id_rd_addr, id_rs_data, id_rt_data, id_imm, flush, hold,
      input  stall, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write,
             ex_mem_to_reg, ex_reg_write, ex_alu_op, ex_rs_addr, ex_rt_addr,
             ex_write_addr, ex_rs_data, ex_rt_data, ex_imm, bubble_cnt
   );

   modport slave (
      input  id_valid, id_reg_dst, id_alu_src, id_mem_read, id_mem_write,
             id_mem_to_reg, id_reg_write, id_alu_op, id_rs_addr, id_rt_addr,
             id_rd_addr, id_rs_data, id_rt_data, id_imm, flush, hold,
      output stall, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write,
             ex_mem_to_reg, ex_reg_write, ex_alu_op, ex_rs_addr, ex_rt_addr,
             ex_write_addr, ex_rs_data, ex_rt_data, ex_imm, bubble_cnt
   );

endinterface

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// valid instruction in ID. Register $0 never creates a dependency.
module hazard_detection_unit
   import cpu_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              ex_valid_i,
   input  logic              ex_mem_read_i,
   input  logic [REG_AW-1:0] ex_write_addr_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs_addr_i,
   input  logic [REG_AW-1:0] id_rt_addr_i,
   output logic              hazard_o
);

   assign hazard_o = ex_valid_i & ex_mem_read_i & (ex_write_addr_i != '0) &
                     id_valid_i &
                     ((ex_write_addr_i == id_rs_addr_i) |
                      (ex_write_addr_i == id_rt_addr_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, downstream
// hold and a saturating count of hazard bubbles.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              id_valid_i,
   input  logic              id_RegDst_i,
   input  logic              id_ALUSrc_i,
   input  logic              id_MemRead_i,
   input  logic              id_MemWrite_i,
   input  logic              id_MemtoReg_i,
   input  logic              id_RegWrite_i,
   input  logic [1:0]        id_ALUOp_i,
   input  logic [REG_AW-1:0] id_RsAddr_i,
   input  logic [REG_AW-1:0] id_RtAddr_i,
   input  logic [REG_AW-1:0] id_RdAddr_i,
   input  logic [DATA_W-1:0] id_RsData_i,
   input  logic [DATA_W-1:0] id_RtData_i,
   input  logic [DATA_W-1:0] id_Imm_i,
   input  logic              flush_i,
   input  logic              hold_i,

   output logic              stall_o,
   output logic              ex_valid_o,
   output logic              ex_ALUSrc_o,
   output logic              ex_MemRead_o,
   output logic              ex_MemWrite_o,
   output logic              ex_MemtoReg_o,
   output logic              ex_RegWrite_o,
   output logic [1:0]        ex_ALUOp_o,
   output logic [REG_AW-1:0] ex_RsAddr_o,
   output logic [REG_AW-1:0] ex_RtAddr_o,
   output logic [REG_AW-1:0] ex_WriteAddr_o,
   output logic [DATA_W-1:0] ex_RsData_o,
   output logic [DATA_W-1:0] ex_RtData_o,
   output logic [DATA_W-1:0] ex_Imm_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   id_ex_ctrl_t       ctrl_q,       ctrl_d;
   logic [REG_AW-1:0] rs_addr_q,    rs_addr_d;
   logic [REG_AW-1:0] rt_addr_q,    rt_addr_d;
   logic [REG_AW-1:0] write_addr_q, write_addr_d;
   logic [DATA_W-1:0] rs_data_q,    rs_data_d;
   logic [DATA_W-1:0] rt_data_q,    rt_data_d;
   logic [DATA_W-1:0] imm_q,        imm_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
   logic              hazard;

   hazard_detection_unit #(.REG_AW(REG_AW)) u_hazard (
      .ex_valid_i      (ctrl_q.valid),
      .ex_mem_read_i   (ctrl_q.mem_read),
      .ex_write_addr_i (write_addr_q),
      .id_valid_i      (id_valid_i),
      .id_rs_addr_i    (id_RsAddr_i),
      .id_rt_addr_i    (id_RtAddr_i),
      .hazard_o        (hazard)
   );

   // A flush kills the dependent instruction anyway, so it needs no stall.
   assign stall_o = hold_i | (hazard & ~flush_i);

   always_comb begin
      // NOTE: every _d gets its hold value first so no path can infer a latch.
      ctrl_d       = ctrl_q;
      rs_addr_d    = rs_addr_q;
      rt_addr_d    = rt_addr_q;
      write_addr_d = write_addr_q;
      rs_data_d    = rs_data_q;
      rt_data_d    = rt_data_q;
      imm_d        = imm_q;
      bubble_cnt_d = bubble_cnt_q;

      if (!hold_i) begin
         if (flush_i || hazard) begin
            ctrl_d       = CTRL_BUBBLE;
            rs_addr_d    = '0;
            rt_addr_d    = '0;
            write_addr_d = '0;
            rs_data_d    = '0;
            rt_data_d    = '0;
            imm_d        = '0;
            if (hazard && !flush_i && (bubble_cnt_q != '1)) begin
               bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
         end else begin
            ctrl_d.valid      = id_valid_i;
            ctrl_d.alu_src    = id_valid_i & id_ALUSrc_i;
            ctrl_d.mem_read   = id_valid_i & id_MemRead_i;
            ctrl_d.mem_write  = id_valid_i & id_MemWrite_i;
            ctrl_d.mem_to_reg = id_valid_i & id_MemtoReg_i;
            ctrl_d.reg_write  = id_valid_i & id_RegWrite_i;
            ctrl_d.alu_op     = id_valid_i ? alu_op_e'(id_ALUOp_i) : ALU_OP_ADD;
            rs_addr_d         = id_RsAddr_i;
            rt_addr_d         = id_RtAddr_i;
            write_addr_d      = id_RegDst_i ? id_RdAddr_i : id_RtAddr_i;
            rs_data_d         = id_RsData_i;
            rt_data_d         = id_RtData_i;
            imm_d             = id_Imm_i;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q       <= CTRL_BUBBLE;
         rs_addr_q    <= '0;
         rt_addr_q    <= '0;
         write_addr_q <= '0;
         rs_data_q    <= '0;
         rt_data_q    <= '0;
         imm_q        <= '0;
         bubble_cnt_q <= '0;
      end else begin
         ctrl_q       <= ctrl_d;
         rs_addr_q    <= rs_addr_d;
         rt_addr_q    <= rt_addr_d;
         write_addr_q <= write_addr_d;
         rs_data_q    <= rs_data_d;
         rt_data_q    <= rt_data_d;
         imm_q        <= imm_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_valid_o     = ctrl_q.valid;
   assign ex_ALUSrc_o    = ctrl_q.alu_src;
   assign ex_MemRead_o   = ctrl_q.mem_read;
   assign ex_MemWrite_o  = ctrl_q.mem_write;
   assign ex_MemtoReg_o  = ctrl_q.mem_to_reg;
   assign ex_RegWrite_o  = ctrl_q.reg_write;
   assign ex_ALUOp_o     = ctrl_q.alu_op;
   assign ex_RsAddr_o    = rs_addr_q;
   assign ex_RtAddr_o    = rt_addr_q;
   assign ex_WriteAddr_o = write_addr_q;
   assign ex_RsData_o    = rs_data_q;
   assign ex_RtData_o    = rt_data_q;
   assign ex_Imm_o       = imm_q;
   assign bubble_cnt_o   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/hold/RegDst scenarios plus a
// randomized run, all compared against a behavioural model of the EX state.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   // Narrow counter so saturation is reachable in a few hundred cycles.
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();

   id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .id_valid_i     (bus.id_valid),
      .id_RegDst_i    (bus.id_reg_dst),
      .id_ALUSrc_i    (bus.id_alu_src),
      .id_MemRead_i   (bus.id_mem_read),
      .id_MemWrite_i  (bus.id_mem_write),
      .id_MemtoReg_i  (bus.id_mem_to_reg),
      .id_RegWrite_i  (bus.id_reg_write),
      .id_ALUOp_i     (bus.id_alu_op),
      .id_RsAddr_i    (bus.id_rs_addr),
      .id_RtAddr_i    (bus.id_rt_addr),
      .id_RdAddr_i    (bus.id_rd_addr),
      .id_RsData_i    (bus.id_rs_data),
      .id_RtData_i    (bus.id_rt_data),
      .id_Imm_i       (bus.id_imm),
      .flush_i        (bus.flush),
      .hold_i         (bus.hold),
      .stall_o        (bus.stall),
      .ex_valid_o     (bus.ex_valid),
      .ex_ALUSrc_o    (bus.ex_alu_src),
      .ex_MemRead_o   (bus.ex_mem_read),
      .ex_MemWrite_o  (bus.ex_mem_write),
      .ex_MemtoReg_o  (bus.ex_mem_to_reg),
      .ex_RegWrite_o  (bus.ex_reg_write),
      .ex_ALUOp_o     (bus.ex_alu_op),
      .ex_RsAddr_o    (bus.ex_rs_addr),
      .ex_RtAddr_o    (bus.ex_rt_addr),
      .ex_WriteAddr_o (bus.ex_write_addr),
      .ex_RsData_o    (bus.ex_rs_data),
      .ex_RtData_o    (bus.ex_rt_data),
      .ex_Imm_o       (bus.ex_imm),
      .bubble_cnt_o   (bus.bubble_cnt)
   );

   typedef struct packed {
      logic          valid;
      logic          alu_src;
      logic          mem_read;
      logic          mem_write;
      logic          mem_to_reg;
      logic          reg_write;
      logic [1:0]    alu_op;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] wa;
      logic [DW-1:0] rsd;
      logic [DW-1:0] rtd;
      logic [DW-1:0] imm;
      logic [CW-1:0] cnt;
   } ex_view_t;

   ex_view_t mdl = '0;

   function automatic ex_view_t dut_view();
      return {bus.ex_valid, bus.ex_alu_src, bus.ex_mem_read, bus.ex_mem_write,
              bus.ex_mem_to_reg, bus.ex_reg_write, bus.ex_alu_op,
              bus.ex_rs_addr, bus.ex_rt_addr, bus.ex_write_addr,
              bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.bubble_cnt};
   endfunction

   // A valid load in EX writing a non-zero register read by the valid ID instruction.
   function automatic bit mdl_hazard();
      return mdl.valid && mdl.mem_read && (mdl.wa != 0) && bus.id_valid &&
             ((mdl.wa == bus.id_rs_addr) || (mdl.wa == bus.id_rt_addr));
   endfunction

   function automatic bit mdl_stall();
      return bus.hold || (mdl_hazard() && !bus.flush);
   endfunction

   // Advance one clock; the model's next state follows the priority
   // reset > hold > flush > hazard > load.
   task automatic tick();
      ex_view_t nxt = mdl;
      bit hz = mdl_hazard();
      if (rst) begin
         nxt = '0;
      end else if (bus.hold) begin
         nxt = mdl;
      end else if (bus.flush || hz) begin
         nxt = '0;
         nxt.cnt = mdl.cnt;
         if (hz && !bus.flush && mdl.cnt != {CW{1'b1}}) nxt.cnt = CW'(mdl.cnt + 1);
      end else begin
         nxt.valid      = bus.id_valid;
         nxt.alu_src    = bus.id_valid && bus.id_alu_src;
         nxt.mem_read   = bus.id_valid && bus.id_mem_read;
         nxt.mem_write  = bus.id_valid && bus.id_mem_write;
         nxt.mem_to_reg = bus.id_valid && bus.id_mem_to_reg;
         nxt.reg_write  = bus.id_valid && bus.id_reg_write;
         nxt.alu_op     = bus.id_valid ? bus.id_alu_op : 2'b00;
         nxt.rs         = bus.id_rs_addr;
         nxt.rt         = bus.id_rt_addr;
         nxt.wa         = bus.id_reg_dst ? bus.id_rd_addr : bus.id_rt_addr;
         nxt.rsd        = bus.id_rs_data;
         nxt.rtd        = bus.id_rt_data;
         nxt.imm        = bus.id_imm;
      end
      @(posedge clk);
      mdl = nxt;
      #1;
   endtask

   task automatic drive_instr(input bit valid, input bit mem_read, input bit reg_dst,
                              input int rs, input int rt, input int rd);
      bus.id_valid      = valid;
      bus.id_mem_read   = mem_read;
      bus.id_reg_dst    = reg_dst;
      bus.id_alu_src    = mem_read;
      bus.id_mem_to_reg = mem_read;
      bus.id_mem_write  = 1'b0;
      bus.id_reg_write  = 1'b1;
      bus.id_alu_op     = mem_read ? 2'b00 : 2'b10;
      bus.id_rs_addr    = AW'(rs);
      bus.id_rt_addr    = AW'(rt);
      bus.id_rd_addr    = AW'(rd);
      bus.id_rs_data    = $urandom;
      bus.id_rt_data    = $urandom;
      bus.id_imm        = $urandom;
      bus.flush         = 1'b0;
      bus.hold          = 1'b0;
   endtask

   task automatic drive_random(input int hold_pct, input int flush_pct);
      bus.id_valid      = ($urandom_range(0, 3) != 0);
      bus.id_reg_dst    = 1'($urandom);
      bus.id_alu_src    = 1'($urandom);
      bus.id_mem_read   = 1'($urandom);
      bus.id_mem_write  = 1'($urandom);
      bus.id_mem_to_reg = 1'($urandom);
      bus.id_reg_write  = 1'($urandom);
      bus.id_alu_op     = 2'($urandom);
      bus.id_rs_addr    = AW'($urandom_range(0, 3));
      bus.id_rt_addr    = AW'($urandom_range(0, 3));
      bus.id_rd_addr    = AW'($urandom_range(0, 3));
      bus.id_rs_data    = $urandom;
      bus.id_rt_data    = $urandom;
      bus.id_imm        = $urandom;
      bus.hold          = ($urandom_range(0, 99) < hold_pct);
      bus.flush         = ($urandom_range(0, 99) < flush_pct);
   endtask

   task automatic test_reset();
      drive_random(0, 0);
      rst = 1'b1;
      bus.hold = 1'b1;
      tick();
      checks++;
      if (dut_view() !== ex_view_t'('0)) begin
         errors++; $display("FAIL reset_over_hold: got %h want 0", dut_view());
      end
      bus.hold = 1'b0;
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++; $display("FAIL stall_in_reset: got %b want 0", bus.stall);
      end
      tick();
      rst = 1'b0;
      drive_instr(1, 0, 1, 1, 2, 3);
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++; $display("FAIL stall_after_reset: got %b want 0", bus.stall);
      end
   endtask

   task automatic test_load_use();
      logic [CW-1:0] c0;
      drive_instr(0, 0, 0, 0, 0, 0);
      tick();
      drive_instr(1, 1, 0, 1, 2, 9);   // lw $2
      tick();
      drive_instr(1, 0, 1, 2, 3, 4);   // add $4, $2, $3
      #1;
      checks++;
      if (bus.stall !== 1'b1 || mdl_stall() !== 1'b1) begin
         errors++; $display("FAIL load_use_stall: got %b want 1", bus.stall);
      end
      c0 = mdl.cnt;
      tick();
      checks++;
      if (bus.ex_valid !== 1'b0 || bus.bubble_cnt !== CW'(c0 + 1) || dut_view() !== mdl) begin
         errors++; $display("FAIL load_use_bubble: got %h want %h", dut_view(), mdl);
      end
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++; $display("FAIL load_use_release: got %b want 0", bus.stall);
      end
      tick();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_rs_addr !== AW'(2) ||
          bus.ex_write_addr !== AW'(4) || dut_view() !== mdl) begin
         errors++; $display("FAIL load_use_enter: got %h want %h", dut_view(), mdl);
      end
   endtask

   task automatic test_zero_reg();
      logic [CW-1:0] c0;
      drive_instr(1, 1, 0, 5, 0, 9);   // lw $0
      tick();
      drive_instr(1, 0, 1, 0, 6, 7);
      #1;
      c0 = mdl.cnt;
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++; $display("FAIL zero_reg_stall: got %b want 0", bus.stall);
      end
      tick();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.bubble_cnt !== c0 || dut_view() !== mdl) begin
         errors++; $display("FAIL zero_reg_no_bubble: got %h want %h", dut_view(), mdl);
      end
   endtask

   task automatic test_hazard_flush();
      logic [CW-1:0] c0;
      drive_instr(1, 1, 0, 1, 2, 9);
      tick();
      drive_instr(1, 0, 1, 2, 3, 4);
      bus.flush = 1'b1;
      #1;
      c0 = mdl.cnt;
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++; $display("FAIL flush_hazard_stall: got %b want 0", bus.stall);
      end
      tick();
      checks++;
      if (bus.ex_valid !== 1'b0 || bus.bubble_cnt !== c0 || dut_view() !== mdl) begin
         errors++; $display("FAIL flush_hazard_bubble: got %h want %h", dut_view(), mdl);
      end
   endtask

   task automatic test_hold();
      ex_view_t snap;
      drive_instr(1, 1, 0, 1, 2, 9);
      tick();
      snap = mdl;
      for (int i = 0; i < 3; i++) begin
         drive_random(100, 50);
         bus.id_rs_addr = AW'(2);      // would be a hazard if hold did not win
         #1;
         checks++;
         if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL hold_stall[%0d]: got %b want 1", i, bus.stall);
         end
         tick();
         checks++;
         if (dut_view() !== snap) begin
            errors++; $display("FAIL hold_keep[%0d]: got %h want %h", i, dut_view(), snap);
         end
      end
   endtask

   task automatic test_regdst();
      drive_instr(0, 0, 0, 0, 0, 0);
      tick();
      drive_instr(1, 0, 1, 1, 3, 7);
      tick();
      checks++;
      if (bus.ex_write_addr !== AW'(7) || dut_view() !== mdl) begin
         errors++; $display("FAIL regdst_rd: got %0d want 7", bus.ex_write_addr);
      end
      drive_instr(1, 0, 0, 1, 3, 7);
      tick();
      checks++;
      if (bus.ex_write_addr !== AW'(3) || dut_view() !== mdl) begin
         errors++; $display("FAIL regdst_rt: got %0d want 3", bus.ex_write_addr);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive_random(10, 10);
         #1;
         checks++;
         if (bus.stall !== mdl_stall()) begin
            errors++; $display("FAIL rand_stall[%0d]: got %b want %b", i, bus.stall, mdl_stall());
         end
         tick();
         checks++;
         if (dut_view() !== mdl) begin
            errors++; $display("FAIL rand_ex[%0d]: got %h want %h", i, dut_view(), mdl);
         end
      end
   endtask

   task automatic test_saturation();
      int budget = 4 * (1 << CW) + 16;
      int n = 0;
      drive_instr(0, 0, 0, 0, 0, 0);
      tick();
      // A lw that depends on its own destination: hazard every other cycle.
      drive_instr(1, 1, 0, 2, 2, 0);
      while (mdl.cnt != {CW{1'b1}} && n < budget) begin
         #1;
         checks++;
         if (bus.stall !== mdl_stall()) begin
            errors++; $display("FAIL sat_stall[%0d]: got %b want %b", n, bus.stall, mdl_stall());
         end
         tick();
         checks++;
         if (dut_view() !== mdl) begin
            errors++; $display("FAIL sat_ex[%0d]: got %h want %h", n, dut_view(), mdl);
         end
         n++;
      end
      checks++;
      if (bus.bubble_cnt !== {CW{1'b1}}) begin
         errors++; $display("FAIL sat_reached: got %h want all-ones", bus.bubble_cnt);
      end
      n = 0;
      while (!mdl_stall() && n < 4) begin
         tick();
         n++;
      end
      checks++;
      if (bus.stall !== 1'b1) begin
         errors++; $display("FAIL sat_next_hazard: got %b want 1", bus.stall);
      end
      tick();
      checks++;
      if (bus.bubble_cnt !== {CW{1'b1}} || bus.ex_valid !== 1'b0) begin
         errors++; $display("FAIL sat_hold: got %h want all-ones", bus.bubble_cnt);
      end
      tick();   // lw re-enters EX, next cycle stalls again
      checks++;
      if (bus.stall !== 1'b1) begin
         errors++; $display("FAIL pre_reset_stall: got %b want 1", bus.stall);
      end
      rst = 1'b1;
      bus.hold = 1'b1;
      tick();
      checks++;
      if (dut_view() !== ex_view_t'('0)) begin
         errors++; $display("FAIL reset_mid_stall: got %h want 0", dut_view());
      end
      bus.hold = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++; $display("FAIL stall_after_mid_reset: got %b want 0", bus.stall);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load_use();
      test_zero_reg();
      test_hazard_flush();
      test_hold();
      test_regdst();
      test_random();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
